// File: rtl/rgb_pixel_collector.sv
// Assembles R,G,B beats from denoise into packed pixel words.
// Buffers words in a small FIFO; drops on overflow and keeps sticky error flags.
module rgb_pixel_collector #(
    parameter int COLOR_DEPTH = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_W       = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [COLOR_DEPTH-1:0]   pixel_in,
    input  logic                     valid_in,
    input  logic [1:0]               color_in,
    input  logic                     last_col_in,
    input  logic                     last_pic_in,
    output logic [3*COLOR_DEPTH-1:0] rgb_data,
    output logic                     rgb_valid,
    input  logic                     rgb_ready,
    output logic                     rgb_last_col,
    output logic                     rgb_last_pic,
    output logic                     seq_err,
    output logic                     ovf_err,
    input  logic                     err_clr,
    output logic [CNT_W-1:0]         pix_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = 3 * COLOR_DEPTH;

    localparam logic [1:0] RED   = 2'd0;
    localparam logic [1:0] GREEN = 2'd1;
    localparam logic [1:0] BLUE  = 2'd2;

    typedef enum logic [1:0] {
        WAIT_R,
        WAIT_G,
        WAIT_B
    } state_t;

    state_t                 state;
    logic [COLOR_DEPTH-1:0] r_q;
    logic [COLOR_DEPTH-1:0] g_q;

    logic [DW-1:0]          mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  mem_col;
    logic [FIFO_DEPTH-1:0]  mem_pic;
    logic [AW:0]            wr_ptr;
    logic [AW:0]            rd_ptr;
    logic [AW-1:0]          wr_idx;
    logic [AW-1:0]          rd_idx;

    logic full;
    logic empty;
    logic pop;
    logic blue_done;
    logic push_ok;
    logic seq_set;

    assign wr_idx    = wr_ptr[AW-1:0];
    assign rd_idx    = rd_ptr[AW-1:0];
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign pop       = !empty && rgb_ready;
    assign blue_done = valid_in && (state == WAIT_B) && (color_in == BLUE);
    // A full FIFO still takes the word when the head leaves in the same cycle
    assign push_ok   = blue_done && (!full || pop);

    assign rgb_valid    = !empty;
    assign rgb_data     = mem_data[rd_idx];
    assign rgb_last_col = mem_col[rd_idx];
    assign rgb_last_pic = mem_pic[rd_idx];

    always_comb begin
        seq_set = 1'b0;
        if (valid_in) begin
            case (state)
                WAIT_R:  seq_set = (color_in != RED);
                WAIT_G:  seq_set = (color_in != GREEN);
                WAIT_B:  seq_set = (color_in != BLUE);
                default: seq_set = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_R;
            r_q   <= '0;
            g_q   <= '0;
        end else if (valid_in) begin
            case (state)
                WAIT_R: begin
                    if (color_in == RED) begin
                        r_q   <= pixel_in;
                        state <= WAIT_G;
                    end
                end
                WAIT_G, WAIT_B: begin
                    // A stray RED restarts the pixel rather than discarding it
                    if (color_in == RED) begin
                        r_q   <= pixel_in;
                        state <= WAIT_G;
                    end else if (state == WAIT_G && color_in == GREEN) begin
                        g_q   <= pixel_in;
                        state <= WAIT_B;
                    end else begin
                        state <= WAIT_R;
                    end
                end
                default: state <= WAIT_R;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_err <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            seq_err <= seq_set | (seq_err & ~err_clr);
            ovf_err <= (blue_done & ~push_ok) | (ovf_err & ~err_clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
            end
            mem_col <= '0;
            mem_pic <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            pix_cnt <= '0;
        end else begin
            if (push_ok) begin
                mem_data[wr_idx] <= {r_q, g_q, pixel_in};
                mem_col[wr_idx]  <= last_col_in;
                mem_pic[wr_idx]  <= last_pic_in;
                wr_ptr           <= wr_ptr + 1'b1;
                pix_cnt          <= last_pic_in ? '0 : pix_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rgb_pixel_collector.sv
// Directed bench for rgb_pixel_collector: vector table plus
// hand-written sequences for picture, overflow, full push/pop and reset.
module tb_rgb_pixel_collector;

    localparam logic [1:0] RED   = 2'd0;
    localparam logic [1:0] GREEN = 2'd1;
    localparam logic [1:0] BLUE  = 2'd2;
    localparam logic [1:0] VOID  = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [7:0]  pixel_in;
    logic        valid_in;
    logic [1:0]  color_in;
    logic        last_col_in;
    logic        last_pic_in;
    logic [23:0] rgb_data;
    logic        rgb_valid;
    logic        rgb_ready;
    logic        rgb_last_col;
    logic        rgb_last_pic;
    logic        seq_err;
    logic        ovf_err;
    logic        err_clr;
    logic [15:0] pix_cnt;

    int checks = 0;
    int errors = 0;

    logic [25:0] got [$];

    typedef struct packed {
        logic        v;
        logic [1:0]  c;
        logic [7:0]  p;
        logic        lc;
        logic        lp;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [23:0] ed;
        logic        elc;
        logic        elp;
        logic        es;
        logic        eo;
        logic [15:0] ec;
    } vec_t;

    vec_t vq [$];

    rgb_pixel_collector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pixel_in     (pixel_in),
        .valid_in     (valid_in),
        .color_in     (color_in),
        .last_col_in  (last_col_in),
        .last_pic_in  (last_pic_in),
        .rgb_data     (rgb_data),
        .rgb_valid    (rgb_valid),
        .rgb_ready    (rgb_ready),
        .rgb_last_col (rgb_last_col),
        .rgb_last_pic (rgb_last_pic),
        .seq_err      (seq_err),
        .ovf_err      (ovf_err),
        .err_clr      (err_clr),
        .pix_cnt      (pix_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // A word seen with valid&ready at the falling edge pops at the next rising edge
    always @(negedge clk) begin
        if (rst_n && rgb_valid && rgb_ready) begin
            got.push_back({rgb_last_col, rgb_last_pic, rgb_data});
        end
    end

    function automatic logic [23:0] pw(input logic [7:0] k);
        return {k, k + 8'h40, k + 8'h80};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] c, input logic [7:0] p,
                        input logic lc, input logic lp);
        valid_in    = 1'b1;
        color_in    = c;
        pixel_in    = p;
        last_col_in = lc;
        last_pic_in = lp;
        tick();
        valid_in    = 1'b0;
        last_col_in = 1'b0;
        last_pic_in = 1'b0;
    endtask

    task automatic push_pixel(input logic [7:0] k, input logic lc,
                              input logic lp);
        beat(RED, k, 1'b0, 1'b0);
        beat(GREEN, k + 8'h40, 1'b0, 1'b0);
        beat(BLUE, k + 8'h80, lc, lp);
    endtask

    task automatic add(input logic v, input logic [1:0] c,
                       input logic [7:0] p, input logic lc,
                       input logic lp, input logic clr,
                       input logic ev, input logic [23:0] ed,
                       input logic elc, input logic elp,
                       input logic es, input logic [15:0] ec);
        vec_t t;
        t.v = v;   t.c = c;     t.p = p;     t.lc = lc;
        t.lp = lp; t.rdy = 1'b1; t.clr = clr;
        t.ev = ev; t.ed = ed;   t.elc = elc; t.elp = elp;
        t.es = es; t.eo = 1'b0; t.ec = ec;
        vq.push_back(t);
    endtask

    task automatic check_words(input string name, input int base,
                               input logic [25:0] exp [$]);
        chk({name, "_count"}, 32'(got.size() - base), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got.size()) begin
                chk($sformatf("%s_word%0d", name, i + 1),
                    32'(got[base + i]), 32'(exp[i]));
            end
        end
    endtask

    initial begin
        logic [25:0] exp [$];
        int base;

        rst_n       = 1'b0;
        pixel_in    = '0;
        valid_in    = 1'b0;
        color_in    = RED;
        last_col_in = 1'b0;
        last_pic_in = 1'b0;
        rgb_ready   = 1'b1;
        err_clr     = 1'b0;

        // v  color  pix   lc lp clr | ev data       lc lp seq cnt
        add(1, RED,   8'h10, 0, 0, 0,  0, 24'h0,      0, 0, 0, 0);
        add(1, BLUE,  8'h30, 0, 0, 0,  0, 24'h0,      0, 0, 1, 0);
        add(0, RED,   8'h00, 0, 0, 1,  0, 24'h0,      0, 0, 0, 0);
        add(1, RED,   8'h11, 0, 0, 0,  0, 24'h0,      0, 0, 0, 0);
        add(1, GREEN, 8'h22, 0, 0, 0,  0, 24'h0,      0, 0, 0, 0);
        add(1, RED,   8'h33, 0, 0, 0,  0, 24'h0,      0, 0, 1, 0);
        add(1, GREEN, 8'h44, 0, 0, 0,  0, 24'h0,      0, 0, 1, 0);
        add(1, BLUE,  8'h55, 0, 0, 0,  1, 24'h334455, 0, 0, 1, 1);
        add(0, RED,   8'h00, 0, 0, 0,  0, 24'h0,      0, 0, 1, 1);
        add(1, GREEN, 8'h00, 0, 0, 1,  0, 24'h0,      0, 0, 1, 1);
        add(0, RED,   8'h00, 0, 0, 1,  0, 24'h0,      0, 0, 0, 1);
        add(1, RED,   8'h01, 0, 0, 0,  0, 24'h0,      0, 0, 0, 1);
        add(1, VOID,  8'h00, 0, 0, 0,  0, 24'h0,      0, 0, 1, 1);
        add(1, GREEN, 8'h02, 0, 0, 0,  0, 24'h0,      0, 0, 1, 1);
        add(0, RED,   8'h00, 0, 0, 1,  0, 24'h0,      0, 0, 0, 1);
        add(1, BLUE,  8'h03, 0, 0, 0,  0, 24'h0,      0, 0, 1, 1);
        add(1, RED,   8'hAA, 0, 0, 1,  0, 24'h0,      0, 0, 0, 1);
        add(1, GREEN, 8'hBB, 0, 0, 0,  0, 24'h0,      0, 0, 0, 1);
        add(1, GREEN, 8'hCC, 0, 0, 0,  0, 24'h0,      0, 0, 1, 1);
        add(1, BLUE,  8'hDD, 0, 0, 0,  0, 24'h0,      0, 0, 1, 1);
        add(1, RED,   8'h01, 0, 0, 1,  0, 24'h0,      0, 0, 0, 1);
        add(1, GREEN, 8'h02, 0, 0, 0,  0, 24'h0,      0, 0, 0, 1);
        add(1, BLUE,  8'h03, 1, 1, 0,  1, 24'h010203, 1, 1, 0, 0);
        add(0, RED,   8'h00, 0, 0, 0,  0, 24'h0,      0, 0, 0, 0);

        #12;
        chk("rst_valid", 32'(rgb_valid), 32'd0);
        chk("rst_data", 32'(rgb_data), 32'd0);
        chk("rst_flags", 32'({rgb_last_col, rgb_last_pic}), 32'd0);
        chk("rst_err", 32'({seq_err, ovf_err}), 32'd0);
        chk("rst_cnt", 32'(pix_cnt), 32'd0);
        #10 rst_n = 1'b1;
        tick();

        foreach (vq[i]) begin
            valid_in    = vq[i].v;
            color_in    = vq[i].c;
            pixel_in    = vq[i].p;
            last_col_in = vq[i].lc;
            last_pic_in = vq[i].lp;
            rgb_ready   = vq[i].rdy;
            err_clr     = vq[i].clr;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(rgb_valid), 32'(vq[i].ev));
            chk($sformatf("vec%0d_seq", i), 32'(seq_err), 32'(vq[i].es));
            chk($sformatf("vec%0d_ovf", i), 32'(ovf_err), 32'(vq[i].eo));
            chk($sformatf("vec%0d_cnt", i), 32'(pix_cnt), 32'(vq[i].ec));
            if (vq[i].ev) begin
                chk($sformatf("vec%0d_data", i), 32'(rgb_data), 32'(vq[i].ed));
                chk($sformatf("vec%0d_flags", i),
                    32'({rgb_last_col, rgb_last_pic}),
                    32'({vq[i].elc, vq[i].elp}));
            end
        end
        valid_in    = 1'b0;
        err_clr     = 1'b0;
        last_col_in = 1'b0;
        last_pic_in = 1'b0;

        // Nominal 32-pixel picture, one beat every third cycle
        base = got.size();
        exp.delete();
        rgb_ready = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            logic [7:0] kk;
            logic       lc;
            logic       lp;
            kk = 8'(k);
            lc = (k == 16) || (k == 32);
            lp = (k == 32);
            exp.push_back({lc, lp, pw(kk)});
            beat(RED, kk, 1'b0, 1'b0);
            tick(); tick();
            beat(GREEN, kk + 8'h40, 1'b0, 1'b0);
            tick(); tick();
            beat(BLUE, kk + 8'h80, lc, lp);
            if (k == 31) chk("pic_cnt31", 32'(pix_cnt), 32'd31);
            if (k == 32) chk("pic_cnt_wrap", 32'(pix_cnt), 32'd0);
            tick(); tick();
        end
        repeat (4) tick();
        check_words("pic", base, exp);
        chk("pic_err", 32'({seq_err, ovf_err}), 32'd0);

        // Overflow: five pixels into a 4-deep FIFO with the consumer stalled
        base = got.size();
        exp.delete();
        rgb_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            push_pixel(8'(k), 1'b0, 1'b0);
            if (k <= 4) exp.push_back({2'b00, pw(8'(k))});
            if (k == 4) chk("ovf_before", 32'(ovf_err), 32'd0);
        end
        chk("ovf_set", 32'(ovf_err), 32'd1);
        chk("ovf_cnt", 32'(pix_cnt), 32'd4);
        chk("ovf_head", 32'(rgb_data), 32'(pw(8'd1)));
        tick();
        chk("ovf_hold", 32'(rgb_data), 32'(pw(8'd1)));
        rgb_ready = 1'b1;
        repeat (6) tick();
        check_words("ovf", base, exp);
        chk("ovf_drained", 32'(rgb_valid), 32'd0);
        chk("ovf_cnt_after", 32'(pix_cnt), 32'd4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf_clr", 32'(ovf_err), 32'd0);

        // Full FIFO with a BLUE push and a pop on the same edge
        base = got.size();
        exp.delete();
        rgb_ready = 1'b0;
        for (int k = 8'h11; k <= 8'h15; k++) begin
            exp.push_back({2'b00, pw(8'(k))});
        end
        for (int k = 8'h11; k <= 8'h14; k++) begin
            push_pixel(8'(k), 1'b0, 1'b0);
        end
        beat(RED, 8'h15, 1'b0, 1'b0);
        beat(GREEN, 8'h55, 1'b0, 1'b0);
        rgb_ready = 1'b1;
        beat(BLUE, 8'h95, 1'b0, 1'b0);
        chk("full_ovf", 32'(ovf_err), 32'd0);
        chk("full_cnt", 32'(pix_cnt), 32'd9);
        chk("full_head", 32'(rgb_data), 32'(pw(8'h12)));
        repeat (7) tick();
        check_words("full", base, exp);

        // Asynchronous reset mid-pixel with two words buffered
        rgb_ready = 1'b0;
        push_pixel(8'h21, 1'b0, 1'b0);
        push_pixel(8'h22, 1'b0, 1'b0);
        beat(RED, 8'h23, 1'b0, 1'b0);
        beat(GREEN, 8'h63, 1'b0, 1'b0);
        chk("pre_rst_valid", 32'(rgb_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rgb_valid), 32'd0);
        chk("mid_rst_data", 32'(rgb_data), 32'd0);
        chk("mid_rst_flags", 32'({rgb_last_col, rgb_last_pic}), 32'd0);
        chk("mid_rst_err", 32'({seq_err, ovf_err}), 32'd0);
        chk("mid_rst_cnt", 32'(pix_cnt), 32'd0);
        #3 rst_n = 1'b1;
        tick();
        base = got.size();
        exp.delete();
        exp.push_back({2'b00, pw(8'h31)});
        rgb_ready = 1'b1;
        push_pixel(8'h31, 1'b0, 1'b0);
        chk("post_rst_cnt", 32'(pix_cnt), 32'd1);
        repeat (4) tick();
        check_words("post_rst", base, exp);
        chk("post_rst_seq", 32'(seq_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
